// File: rtl/big_and.sv
// Four-input AND leaf cell with a registered output and saturating/wrapping
// switching-activity counters for power-trace and toggle-count flows.

module big_and_cnt #(
   parameter int CW  = 8,
   parameter bit SAT = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          inc,
   output logic [CW-1:0] cnt
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;          // clear wins over a same-cycle increment
      else if (inc) begin
         if (SAT && (&cnt))
            cnt <= cnt;
         else
            cnt <= cnt + CW'(1);
      end
   end
endmodule

module big_and #(
   parameter int CW  = 8,
   parameter bit SAT = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          a,
   input  logic          b,
   input  logic          c,
   input  logic          d,
   input  logic          cnt_clr,
   output logic          o,
   output logic          o_q,
   output logic [CW-1:0] a_tgl,
   output logic [CW-1:0] b_tgl,
   output logic [CW-1:0] c_tgl,
   output logic [CW-1:0] d_tgl,
   output logic [CW-1:0] o_rise,
   output logic [CW-1:0] o_high
);
   localparam int NUM_CNT = 6;

   logic [3:0]                    in_v;
   logic [3:0]                    in_p;
   logic                          o_p;
   logic [NUM_CNT-1:0]            inc;
   logic [NUM_CNT-1:0][CW-1:0]    cnt;

   assign o    = a & b & c & d;
   assign in_v = {d, c, b, a};

   // Counter slots: 0..3 input toggles, 4 output rising edges, 5 output-high cycles.
   assign inc[3:0] = in_v ^ in_p;
   assign inc[4]   = o & ~o_p;
   assign inc[5]   = o;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_q  <= 1'b0;
         o_p  <= 1'b0;
         in_p <= '0;
      end else begin
         o_q  <= o;
         o_p  <= o;
         in_p <= in_v;
      end
   end

   for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
      big_and_cnt #(.CW(CW), .SAT(SAT)) u_cnt (
         .clk (clk),
         .rst (rst),
         .clr (cnt_clr),
         .inc (inc[i]),
         .cnt (cnt[i])
      );
   end

   assign a_tgl  = cnt[0];
   assign b_tgl  = cnt[1];
   assign c_tgl  = cnt[2];
   assign d_tgl  = cnt[3];
   assign o_rise = cnt[4];
   assign o_high = cnt[5];
endmodule

// File: tb/tb_big_and.sv
// Directed bench for big_and: combinational truth, registered path, activity
// counts, CW=2 saturate/wrap behaviour, clear-vs-increment and async reset.
`timescale 1ns/1ps

module tb_big_and;
   logic clk = 1'b0;
   logic rst, a, b, c, d, cnt_clr;
   logic o, o_q;
   logic [7:0] a_tgl, b_tgl, c_tgl, d_tgl, o_rise, o_high;
   logic s_o, s_oq, w_o, w_oq;
   logic [1:0] s_a, s_b, s_c, s_d, s_r, s_h;
   logic [1:0] w_a, w_b, w_c, w_d, w_r, w_h;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   big_and dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .cnt_clr(cnt_clr),
      .o(o), .o_q(o_q), .a_tgl(a_tgl), .b_tgl(b_tgl), .c_tgl(c_tgl),
      .d_tgl(d_tgl), .o_rise(o_rise), .o_high(o_high)
   );

   big_and #(.CW(2), .SAT(1'b1)) dut_s (
      .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .cnt_clr(cnt_clr),
      .o(s_o), .o_q(s_oq), .a_tgl(s_a), .b_tgl(s_b), .c_tgl(s_c),
      .d_tgl(s_d), .o_rise(s_r), .o_high(s_h)
   );

   big_and #(.CW(2), .SAT(1'b0)) dut_w (
      .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .cnt_clr(cnt_clr),
      .o(w_o), .o_q(w_oq), .a_tgl(w_a), .b_tgl(w_b), .c_tgl(w_c),
      .d_tgl(w_d), .o_rise(w_r), .o_high(w_h)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic set_in(input logic [3:0] abcd);
      {a, b, c, d} = abcd;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   logic [3:0] vec [5]     = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111};
   logic       vec_o [5]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   logic [1:0] sat_exp [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
   logic [1:0] wrp_exp [6] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};

   initial begin
      rst = 1'b1;
      cnt_clr = 1'b0;
      set_in(4'b0000);

      // Combinational truth while held in reset; o must follow within the step.
      for (int i = 0; i < 5; i++) begin
         set_in(vec[i]);
         #0.2;
         chk($sformatf("comb_o[%0d]", i), {31'b0, o}, {31'b0, vec_o[i]});
         #0.8;
      end
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("comb_hold", {31'b0, o}, 32'd1);
      end

      chk("rst_oq", {31'b0, o_q}, 32'd0);
      chk("rst_a_tgl", {24'b0, a_tgl}, 32'd0);
      chk("rst_o_high", {24'b0, o_high}, 32'd0);
      chk("rst_o_rise", {24'b0, o_rise}, 32'd0);

      // Registered path and activity counts
      set_in(4'b0000);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         set_in(vec[i]);
         tick();
         chk($sformatf("reg_oq[%0d]", i), {31'b0, o_q}, {31'b0, vec_o[i]});
         if (i == 2) begin
            chk("mid_a_tgl", {24'b0, a_tgl}, 32'd1);
            chk("mid_c_tgl", {24'b0, c_tgl}, 32'd0);
         end
      end
      repeat (10) tick();
      chk("cnt_a_tgl", {24'b0, a_tgl}, 32'd1);
      chk("cnt_b_tgl", {24'b0, b_tgl}, 32'd1);
      chk("cnt_c_tgl", {24'b0, c_tgl}, 32'd1);
      chk("cnt_d_tgl", {24'b0, d_tgl}, 32'd1);
      chk("cnt_o_rise", {24'b0, o_rise}, 32'd1);
      chk("cnt_o_high", {24'b0, o_high}, 32'd11);

      // Async reset between edges: we are 1 ns past an edge.
      #2;
      rst = 1'b1;
      #1;
      chk("arst_a_tgl", {24'b0, a_tgl}, 32'd0);
      chk("arst_o_high", {24'b0, o_high}, 32'd0);
      chk("arst_o_rise", {24'b0, o_rise}, 32'd0);
      chk("arst_oq", {31'b0, o_q}, 32'd0);
      chk("arst_o", {31'b0, o}, 32'd1);
      #1;
      chk("arst_o_late", {31'b0, o}, 32'd1);

      // Saturate vs wrap on CW=2: toggle a every cycle starting from 0.
      set_in(4'b0000);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         a = ~a;
         tick();
         chk($sformatf("sat_a_tgl[%0d]", k), {30'b0, s_a}, {30'b0, sat_exp[k]});
         chk($sformatf("wrap_a_tgl[%0d]", k), {30'b0, w_a}, {30'b0, wrp_exp[k]});
      end
      chk("wide_a_tgl", {24'b0, a_tgl}, 32'd6);

      // Clear in the same cycle a toggles, then a toggle two cycles later.
      a = ~a;
      cnt_clr = 1'b1;
      tick();
      chk("clr_a_tgl", {24'b0, a_tgl}, 32'd0);
      cnt_clr = 1'b0;
      tick();
      chk("clr_hold", {24'b0, a_tgl}, 32'd0);
      a = ~a;
      tick();
      chk("clr_after", {24'b0, a_tgl}, 32'd1);
      chk("clr_o_high", {24'b0, o_high}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
